// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: shares one memory port between fetch and data access,
// owns the NZCV flag register. Optional perf counters under SEQ_PERF_CNT_EN.
module multicycle_sequencer #(
  parameter int WAIT_MAX = 15
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic       halt,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       MemToReg,
  input  logic       NoWrite,
  input  logic       B,
  input  logic [1:0] FlagW,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic       mem_ready,
  output logic       MemReq,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags,
  output logic       CondEx,
  output logic       busy,
  output logic       mem_err
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0] cyc_cnt,
  output logic [31:0] instr_cnt
`endif
);

  localparam int WW = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXECUTE, MEMRD, MEMWR, WB
  } state_t;

  state_t        state;
  state_t        ex_next;
  logic [WW-1:0] wait_cnt;
  logic          cond_pass;
  logic          boundary;
  logic          n_f, z_f, c_f, v_f;

  assign {n_f, z_f, c_f, v_f} = Flags;

  always_comb begin
    cond_pass = 1'b0;
    case (Cond)
      4'b0000: cond_pass = z_f;
      4'b0001: cond_pass = !z_f;
      4'b0010: cond_pass = c_f;
      4'b0011: cond_pass = !c_f;
      4'b0100: cond_pass = n_f;
      4'b0101: cond_pass = !n_f;
      4'b0110: cond_pass = v_f;
      4'b0111: cond_pass = !v_f;
      4'b1000: cond_pass = c_f && !z_f;
      4'b1001: cond_pass = !c_f || z_f;
      4'b1010: cond_pass = (n_f == v_f);
      4'b1011: cond_pass = (n_f != v_f);
      4'b1100: cond_pass = !z_f && (n_f == v_f);
      4'b1101: cond_pass = z_f || (n_f != v_f);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // EXECUTE dispatch: first matching rule wins
  always_comb begin
    ex_next = FETCH;
    if (cond_pass) begin
      if (B || PCS)               ex_next = FETCH;
      else if (MemW)              ex_next = MEMWR;
      else if (MemToReg)          ex_next = MEMRD;
      else if (RegW && !NoWrite)  ex_next = WB;
      else                        ex_next = FETCH;
    end
  end

  always_comb begin
    boundary = ((state == EXECUTE) && (ex_next == FETCH)) ||
               ((state == MEMWR) && mem_ready) ||
               (state == WB);
  end

  always_comb begin
    MemReq   = 1'b0;
    AdrSrc   = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    CondEx   = 1'b0;
    busy     = (state != IDLE);
    case (state)
      FETCH: begin
        MemReq  = 1'b1;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      EXECUTE: begin
        CondEx  = cond_pass;
        PCWrite = cond_pass && (B || PCS);
      end
      MEMRD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
      end
      MEMWR: begin
        MemReq   = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      WB:      RegWrite = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      Flags    <= '0;
      mem_err  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      wait_cnt <= '0;
      if (boundary) begin
        state <= halt ? IDLE : FETCH;
      end else begin
        case (state)
          IDLE:    if (start) state <= FETCH;
          DECODE:  state <= EXECUTE;
          EXECUTE: state <= ex_next;
          FETCH, MEMRD, MEMWR: begin
            if (mem_ready) begin
              if (state == FETCH)      state <= DECODE;
              else if (state == MEMRD) state <= WB;
            end else if (wait_cnt == WW'(WAIT_MAX - 1)) begin
              mem_err <= 1'b1;
              state   <= IDLE;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
      if ((state == EXECUTE) && cond_pass) begin
        if (FlagW[1]) Flags[3:2] <= ALUFlags[3:2];
        if (FlagW[0]) Flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      cyc_cnt   <= '0;
      instr_cnt <= '0;
    end else begin
      if (busy)     cyc_cnt   <= cyc_cnt + 32'd1;
      if (boundary) instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer; strobes checked as one packed vector.
module tb_multicycle_sequencer;

  logic       CLK = 1'b0;
  logic       RST, start, halt, PCS, RegW, MemW, MemToReg, NoWrite, B, mem_ready;
  logic [1:0] FlagW;
  logic [3:0] Cond, ALUFlags;
  logic       MemReq, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, CondEx, busy, mem_err;
  logic [3:0] Flags;
  logic [7:0] outs;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cyc_cnt, instr_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  multicycle_sequencer #(.WAIT_MAX(15)) dut (
    .CLK(CLK), .RST(RST), .start(start), .halt(halt), .PCS(PCS), .RegW(RegW),
    .MemW(MemW), .MemToReg(MemToReg), .NoWrite(NoWrite), .B(B), .FlagW(FlagW),
    .Cond(Cond), .ALUFlags(ALUFlags), .mem_ready(mem_ready), .MemReq(MemReq),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .Flags(Flags), .CondEx(CondEx), .busy(busy), .mem_err(mem_err)
`ifdef SEQ_PERF_CNT_EN
    , .cyc_cnt(cyc_cnt), .instr_cnt(instr_cnt)
`endif
  );

  // {MemReq,AdrSrc,IRWrite,PCWrite,RegWrite,MemWrite,CondEx,busy}
  assign outs = {MemReq, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, CondEx, busy};

  localparam logic [7:0] O_IDLE = 8'h00, O_FRDY = 8'hB1, O_FWAIT = 8'h81, O_DEC = 8'h01,
                         O_EXP = 8'h03, O_EXF = 8'h01, O_EXBR = 8'h13, O_WB = 8'h09,
                         O_MRD = 8'hC1, O_MWR = 8'hC5;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    #1;
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1; start = 0; halt = 0; PCS = 0; RegW = 0; MemW = 0; MemToReg = 0;
    NoWrite = 0; B = 0; FlagW = 2'b00; Cond = 4'h0; ALUFlags = 4'h0; mem_ready = 1'b1;
    tick(); tick();
    chk("rst_outs", 32'(outs), 32'(O_IDLE));
    chk("rst_flags", 32'(Flags), 32'h0);
    chk("rst_err", 32'(mem_err), 32'h0);
    RST = 1'b0;
`ifdef SEQ_PERF_CNT_EN
    chk("rst_cyc", cyc_cnt, 32'd0);
    chk("rst_instr", instr_cnt, 32'd0);
`endif

    // ALU op with writeback
    start = 1; RegW = 1; Cond = 4'hE;
    chk("alu_idle", 32'(outs), 32'(O_IDLE));
    tick(); start = 0;
    chk("alu_fetch", 32'(outs), 32'(O_FRDY));
    tick(); chk("alu_dec", 32'(outs), 32'(O_DEC));
    tick(); chk("alu_exec", 32'(outs), 32'(O_EXP));
    tick(); chk("alu_wb", 32'(outs), 32'(O_WB));
    tick(); chk("alu_next_fetch", 32'(outs), 32'(O_FRDY));

    // load with 2 wait cycles
    RegW = 0; MemToReg = 1;
    tick(); tick(); chk("ld_exec", 32'(outs), 32'(O_EXP));
    tick(); mem_ready = 0; chk("ld_wait1", 32'(outs), 32'(O_MRD));
    tick(); chk("ld_wait2", 32'(outs), 32'(O_MRD));
    tick(); mem_ready = 1; chk("ld_ready", 32'(outs), 32'(O_MRD));
    tick(); chk("ld_wb", 32'(outs), 32'(O_WB));
    tick(); chk("ld_fetch", 32'(outs), 32'(O_FRDY));

    // failed EQ with Z=0: no store, flags untouched
    MemToReg = 0; MemW = 1; Cond = 4'h0; FlagW = 2'b11; ALUFlags = 4'hF;
    tick(); tick(); chk("cf_exec", 32'(outs), 32'(O_EXF));
    tick(); chk("cf_fetch", 32'(outs), 32'(O_FRDY));
    chk("cf_flags", 32'(Flags), 32'h0);

    // flag updates, N/Z then C/V
    MemW = 0; Cond = 4'hE; FlagW = 2'b10; ALUFlags = 4'hF;
    tick(); tick(); chk("fl1_exec", 32'(outs), 32'(O_EXP));
    tick(); chk("fl1_flags", 32'(Flags), 32'hC);
    FlagW = 2'b01; ALUFlags = 4'h3;
    tick(); tick(); tick(); chk("fl2_flags", 32'(Flags), 32'hF);
    chk("fl2_fetch", 32'(outs), 32'(O_FRDY));

    // flags now NZCV=1111: EQ passes, NE/GT/never fail, LE passes
    FlagW = 2'b00; B = 1; Cond = 4'h0;
    tick(); tick(); chk("br_eq_exec", 32'(outs), 32'(O_EXBR));
    tick(); chk("br_fetch", 32'(outs), 32'(O_FRDY));
    Cond = 4'h1;
    tick(); tick(); chk("br_ne_exec", 32'(outs), 32'(O_EXF));
    Cond = 4'hC;
    tick(); tick(); tick(); chk("br_gt_exec", 32'(outs), 32'(O_EXF));
    Cond = 4'hD;
    tick(); tick(); tick(); chk("br_le_exec", 32'(outs), 32'(O_EXBR));
    Cond = 4'hF;
    tick(); tick(); tick(); chk("br_nv_exec", 32'(outs), 32'(O_EXF));

    // store ending in halt
    tick(); chk("st_fetch", 32'(outs), 32'(O_FRDY));
    B = 0; MemW = 1; Cond = 4'hE; halt = 1;
    tick(); tick(); chk("st_exec", 32'(outs), 32'(O_EXP));
    tick(); chk("st_memwr", 32'(outs), 32'(O_MWR));
    tick(); chk("st_halt_idle", 32'(outs), 32'(O_IDLE));

    // start and halt together: start wins, halt taken at the first boundary
    MemW = 0; B = 1; start = 1;
    tick(); start = 0; chk("sh_fetch", 32'(outs), 32'(O_FRDY));
    tick(); tick(); chk("sh_exec", 32'(outs), 32'(O_EXBR));
    tick(); chk("sh_idle", 32'(outs), 32'(O_IDLE));
    halt = 0; B = 0;

    // fetch timeout
    mem_ready = 0; start = 1;
    tick(); start = 0; chk("to_fetch", 32'(outs), 32'(O_FWAIT));
    repeat (14) tick();
    chk("to_still_fetch", 32'(outs), 32'(O_FWAIT));
    chk("to_err_pre", 32'(mem_err), 32'h0);
    tick(); chk("to_err", 32'(mem_err), 32'h1);
    chk("to_idle", 32'(outs), 32'(O_IDLE));

    // reset mid-store
    mem_ready = 1; MemW = 1; start = 1;
    tick(); start = 0;
    tick(); tick(); tick(); mem_ready = 0; chk("rs_memwr", 32'(outs), 32'(O_MWR));
    RST = 1;
    tick(); chk("rs_outs", 32'(outs), 32'(O_IDLE));
    chk("rs_err", 32'(mem_err), 32'h0);
    chk("rs_flags", 32'(Flags), 32'h0);
    RST = 0; MemW = 0; mem_ready = 1;

    // three ALU ops then halt
    RegW = 1; start = 1;
    tick(); start = 0;
    repeat (11) tick();
    chk("pc_last_wb", 32'(outs), 32'(O_WB));
    halt = 1;
    tick(); chk("pc_idle", 32'(outs), 32'(O_IDLE));
`ifdef SEQ_PERF_CNT_EN
    chk("pc_cyc", cyc_cnt, 32'd12);
    chk("pc_instr", instr_cnt, 32'd3);
`endif
    halt = 0; RegW = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
